// File: rtl/stepper_step_gen.sv
// -----------------------------------------------------------------------------
// stepper_step_gen
//
// Step/direction pulse generator for a stepper-motor driver. Takes the
// enable, direction and step-period outputs of the current regulator and
// turns them into a step pulse train. The generator provides:
//   - a direction setup time before the first step and after every reversal
//   - a minimum step period (clamp)
//   - soft position limits
//   - a signed step-position count
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low
//   drv_en     in   stepping enable
//   dir        in   requested direction (1 = positive / increment)
//   period     in   requested step period in clk cycles (0 = stop)
//   pos_min    in   signed lower soft limit
//   pos_max    in   signed upper soft limit
//   pos_clr    in   synchronous position clear (wins over a step update)
//   step       out  step pulse to the motor driver
//   dir_out    out  direction line to the motor driver
//   en_out     out  driver enable (drv_en delayed by one cycle)
//   position   out  signed step count, wraps modulo 2^POS_W
//   at_limit   out  a step was inhibited by a soft limit
//   busy       out  state machine is not idle
//   state_dbg  out  current FSM state, for observation only
//
// There is no valid/ready handshake on this block. Its inputs are levels,
// and they are sampled at the state boundaries described below.
// -----------------------------------------------------------------------------
module stepper_step_gen #(
    parameter int WIDTH_TX   = 16,
    parameter int POS_W      = 32,
    parameter int PULSE_W    = 50,
    parameter int DIR_SETUP  = 100,
    parameter int MIN_PERIOD = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    drv_en,
    input  logic                    dir,
    input  logic [2*WIDTH_TX-1:0]   period,
    input  logic signed [POS_W-1:0] pos_min,
    input  logic signed [POS_W-1:0] pos_max,
    input  logic                    pos_clr,
    output logic                    step,
    output logic                    dir_out,
    output logic                    en_out,
    output logic signed [POS_W-1:0] position,
    output logic                    at_limit,
    output logic                    busy,
    output logic [1:0]              state_dbg
);

    localparam int CW = 2 * WIDTH_TX;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_LOW   = 2'd3;

    // Each counter is loaded with (length - 1). The state ends on the cycle
    // the counter reads zero, so every state lasts exactly its length.
    localparam logic [CW-1:0] SETUP_LD = CW'(DIR_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] LOW_ADJ  = CW'(PULSE_W + 1);
    localparam logic [CW-1:0] MIN_P    = CW'(MIN_PERIOD);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] eff_sh;     // period of the step in progress
    logic [CW-1:0] eff_next;   // clamped request, captured at step start

    logic          blocked;
    logic          enter_high;
    logic          load_dir;
    logic          limit_set;

    assign eff_next = (period < MIN_P) ? MIN_P : period;

    // The limit is judged against the requested direction, so the check
    // refers to the direction the next step would actually take.
    assign blocked = (dir  && (position >= pos_max)) ||
                     (!dir && (position <= pos_min));

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_high = 1'b0;
        load_dir   = 1'b0;
        limit_set  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (drv_en && (period != '0)) begin
                    if (blocked) begin
                        limit_set = 1'b1;
                    end else begin
                        state_nx = ST_SETUP;
                        cnt_nx   = SETUP_LD;
                        load_dir = 1'b1;
                    end
                end
            end

            ST_SETUP: begin
                // No pulse has started yet, so an enable drop aborts
                // at once.
                if (!drv_en) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx   = ST_HIGH;
                    cnt_nx     = PULSE_LD;
                    enter_high = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            ST_HIGH: begin
                if (cnt == '0) begin
                    state_nx = ST_LOW;
                    cnt_nx   = eff_sh - LOW_ADJ;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            ST_LOW: begin
                if (cnt == '0) begin
                    if (!drv_en || (period == '0)) begin
                        state_nx = ST_IDLE;
                    end else if (dir != dir_out) begin
                        state_nx = ST_SETUP;
                        cnt_nx   = SETUP_LD;
                        load_dir = 1'b1;
                    end else if (blocked) begin
                        state_nx  = ST_IDLE;
                        limit_set = 1'b1;
                    end else begin
                        state_nx   = ST_HIGH;
                        cnt_nx     = PULSE_LD;
                        enter_high = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter and outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            eff_sh   <= '0;
            step     <= 1'b0;
            dir_out  <= 1'b0;
            en_out   <= 1'b0;
            position <= '0;
            at_limit <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            en_out <= drv_en;

            // The step output is registered from the next state, so it is
            // glitch-free and rises on the same edge that enters HIGH.
            step <= (state_nx == ST_HIGH);

            if (load_dir) begin
                dir_out <= dir;
            end

            if (enter_high) begin
                eff_sh <= eff_next;
            end

            if (enter_high) begin
                at_limit <= 1'b0;
            end else if (limit_set) begin
                at_limit <= 1'b1;
            end

            if (pos_clr) begin
                position <= '0;
            end else if (enter_high) begin
                if (dir_out) begin
                    position <= position + POS_W'(1);
                end else begin
                    position <= position - POS_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stepper_step_gen.sv
module tb_stepper_step_gen;

    localparam int WIDTH_TX   = 16;
    localparam int POS_W      = 32;
    localparam int PULSE_W    = 4;
    localparam int DIR_SETUP  = 8;
    localparam int MIN_PERIOD = 10;

    // ---------------- clock / reset ----------------
    logic                    clk = 1'b0;
    logic                    rst;
    logic                    drv_en;
    logic                    dir;
    logic [2*WIDTH_TX-1:0]   period;
    logic signed [POS_W-1:0] pos_min;
    logic signed [POS_W-1:0] pos_max;
    logic                    pos_clr;
    logic                    step;
    logic                    dir_out;
    logic                    en_out;
    logic signed [POS_W-1:0] position;
    logic                    at_limit;
    logic                    busy;
    logic [1:0]              state_dbg;

    always #5 clk = ~clk;

    stepper_step_gen #(
        .WIDTH_TX  (WIDTH_TX),
        .POS_W     (POS_W),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP),
        .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .drv_en   (drv_en),
        .dir      (dir),
        .period   (period),
        .pos_min  (pos_min),
        .pos_max  (pos_max),
        .pos_clr  (pos_clr),
        .step     (step),
        .dir_out  (dir_out),
        .en_out   (en_out),
        .position (position),
        .at_limit (at_limit),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until step rises, or -1 on timeout.
    task automatic wait_rise(input int max_c, output int n);
        logic prev;
        bit   done;
        prev = step;
        done = 1'b0;
        n    = -1;
        for (int i = 1; i <= max_c && !done; i++) begin
            tick(1);
            if (step && !prev) begin
                n    = i;
                done = 1'b1;
            end
            prev = step;
        end
    endtask

    task automatic wait_idle(input int max_c, output int n);
        bit done;
        done = 1'b0;
        n    = -1;
        for (int i = 1; i <= max_c && !done; i++) begin
            tick(1);
            if (!busy) begin
                n    = i;
                done = 1'b1;
            end
        end
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic        drv_en;
        logic        dir;
        logic [31:0] period;
        int          adv;
        logic        e_step;
        logic        e_dir_out;
        logic        e_en;
        logic        e_busy;
        logic        e_lim;
        logic [1:0]  e_state;
        logic [31:0] e_pos;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int n;
        int rises;
        bit done;

        // Start, clamp and stop sequence, hand-timed for
        // PULSE_W=4, DIR_SETUP=8, MIN_PERIOD=10.
        //           en   dir  period adv stp dro en  bsy lim st    pos
        vecs[0]  = '{1'b0, 1'b1, 32'd20, 1, 0, 0, 0, 0, 0, 2'd0, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'd20, 1, 0, 1, 1, 1, 0, 2'd1, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'd20, 7, 0, 1, 1, 1, 0, 2'd1, 32'd0};
        vecs[3]  = '{1'b1, 1'b1, 32'd20, 1, 1, 1, 1, 1, 0, 2'd2, 32'd1};
        vecs[4]  = '{1'b1, 1'b1, 32'd20, 3, 1, 1, 1, 1, 0, 2'd2, 32'd1};
        vecs[5]  = '{1'b1, 1'b1, 32'd20, 1, 0, 1, 1, 1, 0, 2'd3, 32'd1};
        vecs[6]  = '{1'b1, 1'b1, 32'd20, 15, 0, 1, 1, 1, 0, 2'd3, 32'd1};
        vecs[7]  = '{1'b1, 1'b1, 32'd20, 1, 1, 1, 1, 1, 0, 2'd2, 32'd2};
        vecs[8]  = '{1'b1, 1'b1, 32'd3, 20, 1, 1, 1, 1, 0, 2'd2, 32'd3};
        vecs[9]  = '{1'b1, 1'b1, 32'd3, 4, 0, 1, 1, 1, 0, 2'd3, 32'd3};
        vecs[10] = '{1'b1, 1'b1, 32'd3, 6, 1, 1, 1, 1, 0, 2'd2, 32'd4};
        vecs[11] = '{1'b1, 1'b1, 32'd3, 10, 1, 1, 1, 1, 0, 2'd2, 32'd5};
        vecs[12] = '{1'b1, 1'b1, 32'd0, 2, 1, 1, 1, 1, 0, 2'd2, 32'd5};
        vecs[13] = '{1'b1, 1'b1, 32'd0, 2, 0, 1, 1, 1, 0, 2'd3, 32'd5};
        vecs[14] = '{1'b1, 1'b1, 32'd0, 5, 0, 1, 1, 1, 0, 2'd3, 32'd5};
        vecs[15] = '{1'b1, 1'b1, 32'd0, 1, 0, 1, 1, 0, 0, 2'd0, 32'd5};

        // ---------------- reset ----------------
        rst     = 1'b0;
        drv_en  = 1'b0;
        dir     = 1'b1;
        period  = 32'd20;
        pos_min = -32'sd1000;
        pos_max = 32'sd1000;
        pos_clr = 1'b0;
        tick(3);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pos", position, 32'd0);
        chk("rst_at_limit", 32'(at_limit), 32'd0);
        chk("rst_dir_out", 32'(dir_out), 32'd0);
        chk("rst_en_out", 32'(en_out), 32'd0);
        rst = 1'b1;
        tick(2);

        // ---------------- table-driven start/clamp/stop ----------------
        for (int i = 0; i < 16; i++) begin
            drv_en = vecs[i].drv_en;
            dir    = vecs[i].dir;
            period = vecs[i].period;
            tick(vecs[i].adv);
            chk($sformatf("v%0d_step", i), 32'(step), 32'(vecs[i].e_step));
            chk($sformatf("v%0d_dir_out", i), 32'(dir_out), 32'(vecs[i].e_dir_out));
            chk($sformatf("v%0d_en_out", i), 32'(en_out), 32'(vecs[i].e_en));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_at_limit", i), 32'(at_limit), 32'(vecs[i].e_lim));
            chk($sformatf("v%0d_state", i), 32'(state_dbg), 32'(vecs[i].e_state));
            chk($sformatf("v%0d_pos", i), position, vecs[i].e_pos);
        end

        // ---------------- direction change ----------------
        period = 32'd20;
        dir    = 1'b1;
        wait_rise(40, n);
        chk("dc_first_latency", n, 32'd9);
        chk("dc_first_pos", position, 32'd6);
        dir = 1'b0;
        tick(3);
        chk("dc_pulse_hold", 32'(step), 32'd1);
        tick(1);
        chk("dc_pulse_end", 32'(step), 32'd0);
        tick(15);
        chk("dc_dir_held", 32'(dir_out), 32'd1);
        chk("dc_still_low", 32'(state_dbg), 32'd3);
        tick(1);
        chk("dc_dir_switched", 32'(dir_out), 32'd0);
        chk("dc_setup", 32'(state_dbg), 32'd1);
        wait_rise(40, n);
        chk("dc_setup_gap", n, 32'd8);
        chk("dc_pos_dec", position, 32'd5);

        // ---------------- soft limit ----------------
        drv_en = 1'b0;
        wait_idle(100, n);
        chk("lim_idle_reached", 32'(n > 0), 32'd1);
        pos_clr = 1'b1;
        tick(1);
        pos_clr = 1'b0;
        chk("lim_clr_pos", position, 32'd0);
        pos_max = 32'sd5;
        dir     = 1'b1;
        period  = 32'd10;
        drv_en  = 1'b1;
        rises   = 0;
        done    = 1'b0;
        begin
            logic prev;
            prev = step;
            for (int i = 0; i < 300 && !done; i++) begin
                tick(1);
                if (step && !prev) rises++;
                prev = step;
                if (!busy) done = 1'b1;
            end
        end
        chk("lim_stopped", 32'(done), 32'd1);
        chk("lim_step_count", rises, 32'd5);
        chk("lim_pos", position, 32'd5);
        chk("lim_at_limit", 32'(at_limit), 32'd1);
        tick(3);
        chk("lim_stays_idle", 32'(busy), 32'd0);
        chk("lim_flag_held", 32'(at_limit), 32'd1);
        dir = 1'b0;
        tick(1);
        chk("lim_rev_setup", 32'(state_dbg), 32'd1);
        chk("lim_flag_in_setup", 32'(at_limit), 32'd1);
        wait_rise(40, n);
        chk("lim_rev_latency", n, 32'd8);
        chk("lim_flag_cleared", 32'(at_limit), 32'd0);
        chk("lim_rev_pos", position, 32'd4);

        // ---------------- enable drop during HIGH ----------------
        drv_en = 1'b0;
        tick(3);
        chk("en_pulse_hold", 32'(step), 32'd1);
        tick(1);
        chk("en_pulse_end", 32'(step), 32'd0);
        chk("en_busy_low", 32'(busy), 32'd1);
        tick(5);
        chk("en_busy_last_low", 32'(busy), 32'd1);
        tick(1);
        chk("en_idle", 32'(busy), 32'd0);
        chk("en_en_out", 32'(en_out), 32'd0);
        chk("en_pos", position, 32'd4);

        // ---------------- pos_clr coincident with step entry ----------------
        drv_en = 1'b1;
        tick(8);
        chk("clr_setup_last", 32'(state_dbg), 32'd1);
        pos_clr = 1'b1;
        tick(1);
        pos_clr = 1'b0;
        chk("clr_step", 32'(step), 32'd1);
        chk("clr_wins", position, 32'd0);

        // ---------------- async reset mid-HIGH ----------------
        tick(1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_step", 32'(step), 32'd0);
        chk("ar_pos", position, 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_state", 32'(state_dbg), 32'd0);
        chk("ar_en_out", 32'(en_out), 32'd0);
        rst = 1'b1;
        wait_rise(40, n);
        chk("ar_restart_latency", n, 32'd9);
        chk("ar_restart_pos", position, 32'hFFFF_FFFF);
        chk("ar_restart_dir", 32'(dir_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stepper_step_gen.md
Name: stepper_step_gen

Overview:
- Stepper-motor step/direction pulse generator.
- Sits directly downstream of the TX-mode current regulator and consumes its drv_en_TX, dir_TX and period_TX outputs.
- Converts the requested step period (in clk cycles) into a clean step pulse train with direction setup time, a minimum-period clamp and soft position limits.
- Keeps a signed step-position count.

Parameters:
- WIDTH_TX, 16: regulator data width; the period input is 2*WIDTH_TX bits.
- POS_W, 32: width of the signed position counter and limits.
- PULSE_W, 50: step high time in clk cycles (≥1).
- DIR_SETUP, 100: cycles dir_out is held stable before the first step after idle or after a direction change (≥1).
- MIN_PERIOD, 200: smallest step period in cycles. Must be ≥ 2*PULSE_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- drv_en  in  1  stepping enable (from drv_en_TX).
- dir  in  1  requested direction; 1 = positive/increment (from dir_TX).
- period  in  2*WIDTH_TX  requested step period in clk cycles (from period_TX); 0 = stop.
- pos_min  in  POS_W  signed lower soft limit.
- pos_max  in  POS_W  signed upper soft limit.
- pos_clr  in  1  synchronous position clear.
- step  out  1  step pulse to the motor driver.
- dir_out  out  1  direction line to the motor driver.
- en_out  out  1  driver enable.
- position  out  POS_W  signed step count.
- at_limit  out  1  a step was inhibited by a soft limit.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; step, dir_out, en_out, at_limit, busy = 0; position = 0; all counters = 0. Reset mid-pulse drops step immediately.
- en_out: drv_en registered (1-cycle delay).
- eff_period: max(period, MIN_PERIOD), sampled into a shadow register only at the start of each step (entry to HIGH). Period changes mid-step never alter the current step.
- blocked: (dir=1 and position ≥ pos_max) or (dir=0 and position ≤ pos_min), using signed compare.
- States and transitions:
  - IDLE → SETUP when drv_en=1, period≠0 and not blocked. On this transition: dir_out ← dir, counter loaded.
  - IDLE stays IDLE if blocked; at_limit ← 1.
  - SETUP: lasts exactly DIR_SETUP cycles, then → HIGH. If drv_en falls during SETUP → IDLE, no step is issued.
  - HIGH: step=1 for exactly PULSE_W cycles. position ± 1 (per dir_out) on the entry cycle; at_limit ← 0. Then → LOW.
  - LOW: step=0 for eff_period − PULSE_W cycles. On the last LOW cycle, first matching rule wins:
    - drv_en=0 or period=0 → IDLE.
    - dir ≠ dir_out → SETUP, with dir_out ← dir on that edge.
    - blocked → IDLE, at_limit ← 1.
    - otherwise → HIGH.
- Step timing: rising-edge-to-rising-edge interval in continuous stepping is exactly eff_period cycles.
- Latency: drv_en sampled high at edge N puts the state in SETUP at N+1; first step rises at N+1+DIR_SETUP.
- A pulse is never truncated except by reset. A drv_en drop during HIGH or LOW completes the current step, then goes IDLE.
- A direction change is only applied between steps and always inserts a full SETUP.
- position wraps modulo 2^POS_W.
- pos_clr: position ← 0 next cycle. If coincident with a step increment, clear wins.
- period uses full 2*WIDTH_TX bits unsigned; LOW counter is 2*WIDTH_TX bits wide, so no overflow.
- Limits are checked only in IDLE and at LOW end. A limit change mid-step takes effect at the next step boundary.

Test Plan (bench params PULSE_W=4, DIR_SETUP=8, MIN_PERIOD=10):
- Start: drv_en↑ with dir=1, period=20 → step rises 9 cycles later, high 4 cycles, repeats every 20; position 0→1→2…
- Clamp/stop: period=3 → steps every 10 cycles. Then period=0 mid-step → current step completes, IDLE, busy=0.
- Direction change: toggle dir during HIGH → step finishes, dir_out changes at LOW end, 8-cycle gap, next step decrements position.
- Soft limit: pos_max=5, dir=1 → exactly 5 steps, then IDLE with at_limit=1. Flip dir=0 → stepping resumes, at_limit clears on first step.
- Enable drop / clear: drv_en↓ during HIGH → full 4-cycle pulse, then IDLE. pos_clr coincident with a step entry → position=0.
- Async reset: rst↓ mid-HIGH → step=0 immediately, position=0. rst↑ with drv_en=1 → restarts via SETUP.
